// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: states, opcodes,
// PC-source selects and trap causes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP,
        S_HALT
    } state_t;

    localparam int unsigned OP_ALU_MAX = 32'h13;
    localparam int unsigned OP_JMP     = 32'h18;
    localparam int unsigned OP_BEQ     = 32'h19;
    localparam int unsigned OP_BNE     = 32'h1A;
    localparam int unsigned OP_CALL    = 32'h1B;
    localparam int unsigned OP_RET     = 32'h1C;
    localparam int unsigned OP_LD      = 32'h1D;
    localparam int unsigned OP_ST      = 32'h1E;
    localparam int unsigned OP_HALT    = 32'h1F;

    localparam logic [2:0] PC_INC    = 3'd0;
    localparam logic [2:0] PC_BRANCH = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_CALL   = 3'd3;
    localparam logic [2:0] PC_STACK  = 3'd4;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_ILLEGAL   = 3'd1;
    localparam logic [2:0] CAUSE_OVERFLOW  = 3'd2;
    localparam logic [2:0] CAUSE_UNDERFLOW = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT   = 3'd4;

    // Gap between the ALU range and JMP, plus anything beyond the 5-bit map.
    function automatic logic op_is_illegal(input logic [31:0] op);
        return ((op > OP_ALU_MAX) && (op < OP_JMP)) || (op > OP_HALT);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_seq_if.sv
// Fetch/datapath/memory handshake bundle of the sequencing controller.
// master = controller, slave = surrounding datapath and memory.
interface multicycle_ctrl_seq_if #(
    parameter int OPCODE_W    = 5,
    parameter int STACK_DEPTH = 16
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic                instr_valid;
    logic [OPCODE_W-1:0] opcode;
    logic                zero_flag;
    logic                mem_ready;
    logic                fetch_req;
    logic                ir_load;
    logic                pc_write;
    logic [2:0]          pc_src;
    logic                alu_en;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                stack_push;
    logic                stack_pop;
    logic [DW-1:0]       stack_depth;
    logic                trap;
    logic [2:0]          trap_cause;
    logic                halted;

    modport master (
        input  instr_valid, opcode, zero_flag, mem_ready,
        output fetch_req, ir_load, pc_write, pc_src, alu_en, reg_write,
               mem_read, mem_write, stack_push, stack_pop, stack_depth,
               trap, trap_cause, halted
    );

    modport slave (
        output instr_valid, opcode, zero_flag, mem_ready,
        input  fetch_req, ir_load, pc_write, pc_src, alu_en, reg_write,
               mem_read, mem_write, stack_push, stack_pop, stack_depth,
               trap, trap_cause, halted
    );
endinterface

// File: rtl/call_depth_tracker.sv
// Call-nesting depth counter; saturates at both ends so it never wraps.
module call_depth_tracker #(
    parameter int STACK_DEPTH = 16,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);
    assign full  = (depth == DW'(STACK_DEPTH));
    assign empty = (depth == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DW'(1);
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end
endmodule

// File: rtl/multicycle_ctrl_seq.sv
// Multi-cycle sequencing controller for the 19-bit CPU: fetch/decode/exec/mem/wb
// FSM with call-depth tracking and sticky traps.
module multicycle_ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int STACK_DEPTH = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_ctrl_seq_if.master bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          cause_q, cause_d;
    logic [31:0]         op_ext;
    logic                push, pop, full, empty;
    logic [DW-1:0]       depth;

    assign op_ext = 32'(op_q);

    call_depth_tracker #(
        .STACK_DEPTH (STACK_DEPTH),
        .DW          (DW)
    ) u_depth (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    assign bus.stack_push  = push;
    assign bus.stack_pop   = pop;
    assign bus.stack_depth = depth;
    assign bus.trap_cause  = cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        cause_d       = cause_q;
        push          = 1'b0;
        pop           = 1'b0;
        bus.fetch_req = 1'b0;
        bus.ir_load   = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_src    = PC_INC;
        bus.alu_en    = 1'b0;
        bus.reg_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.trap      = 1'b0;
        bus.halted    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.fetch_req = 1'b1;
                if (bus.instr_valid) begin
                    bus.ir_load  = 1'b1;
                    bus.pc_write = 1'b1;
                    op_d         = bus.opcode;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_is_illegal(op_ext)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (op_ext == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_ext <= OP_ALU_MAX) begin
                    bus.alu_en = 1'b1;
                    state_d    = S_WB;
                end else begin
                    state_d = S_FETCH;
                    case (op_ext)
                        OP_JMP: begin
                            bus.pc_write = 1'b1;
                            bus.pc_src   = PC_JUMP;
                        end
                        OP_BEQ, OP_BNE: begin
                            bus.pc_write = (op_ext == OP_BEQ) ? bus.zero_flag : !bus.zero_flag;
                            bus.pc_src   = PC_BRANCH;
                        end
                        OP_CALL: begin
                            if (full) begin
                                state_d = S_TRAP;
                                cause_d = CAUSE_OVERFLOW;
                            end else begin
                                push         = 1'b1;
                                bus.pc_write = 1'b1;
                                bus.pc_src   = PC_CALL;
                            end
                        end
                        OP_RET: begin
                            if (empty) begin
                                state_d = S_TRAP;
                                cause_d = CAUSE_UNDERFLOW;
                            end else begin
                                pop          = 1'b1;
                                bus.pc_write = 1'b1;
                                bus.pc_src   = PC_STACK;
                            end
                        end
                        OP_LD, OP_ST: begin
                            cnt_d   = '0;
                            state_d = S_MEM;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                bus.mem_read  = (op_ext == OP_LD);
                bus.mem_write = (op_ext != OP_LD);
                // Ready on the final allowed wait cycle still wins over the timeout.
                if (bus.mem_ready) begin
                    state_d = (op_ext == OP_LD) ? S_WB : S_FETCH;
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP: bus.trap   = 1'b1;
            S_HALT: bus.halted = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Randomized instruction-level bench for multicycle_ctrl_seq against a
// per-instruction latency/strobe model with an integer call-depth counter.
module tb_multicycle_ctrl_seq;
    localparam int OPW = 5;
    localparam int SD  = 16;
    localparam int MT  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_seq_if #(.OPCODE_W(OPW), .STACK_DEPTH(SD)) bus ();

    multicycle_ctrl_seq #(
        .OPCODE_W    (OPW),
        .STACK_DEPTH (SD),
        .MEM_TIMEOUT (MT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int m_depth = 0;
    bit m_dead = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.fetch_req, bus.ir_load, bus.pc_write, bus.pc_src, bus.alu_en,
                    bus.reg_write, bus.mem_read, bus.mem_write, bus.stack_push,
                    bus.stack_pop, bus.stack_depth, bus.trap, bus.trap_cause, bus.halted});
    endfunction

    function automatic logic strobes();
        return bus.fetch_req | bus.ir_load | bus.pc_write | bus.alu_en | bus.reg_write |
               bus.mem_read | bus.mem_write | bus.stack_push | bus.stack_pop;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        rst_n = 1'b0;
        #1 chk("reset_outs", outs(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_depth = 0;
        m_dead  = 0;
    endtask

    // Wait for the controller to request an instruction, then present it.
    task automatic present(input int op, input int stall, output bit ok);
        int w;
        ok = 0;
        w  = 0;
        while (!ok && w < 20) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            bus.opcode      = OPW'($urandom);
            bus.mem_ready   = 1'($urandom);
            #1;
            if (bus.fetch_req) begin
                if (stall > 0) stall--;
                else ok = 1;
            end
            w++;
        end
        chk("fetch_ready", 32'(ok), 1);
        if (ok) begin
            bus.instr_valid = 1'b1;
            bus.opcode      = OPW'(op);
            bus.zero_flag   = 1'($urandom);
            #1;
            chk("ir_load", 32'(bus.ir_load), 1);
            chk("accept_pc", 32'({bus.pc_write, bus.pc_src}), 32'h8);
        end
    endtask

    task automatic run(input int op, input bit zf, input int delay, input int stall);
        int e_lat, e_alu, e_wb, e_alu_t, e_wb_t, e_pcw, e_src, e_push, e_pop, e_rd, e_wr, e_cause;
        bit e_trap, e_halt, ok, stop;
        int lat, alu, wb, alu_t, wb_t, pcw, src, psh, pp, rd, wr, k, quiet;
        e_lat = 0; e_alu = 0; e_wb = 0; e_alu_t = -1; e_wb_t = -1; e_pcw = 0; e_src = 0;
        e_push = 0; e_pop = 0; e_rd = 0; e_wr = 0; e_cause = 0; e_trap = 0; e_halt = 0;

        if (op <= 19) begin
            e_lat = 4; e_alu = 1; e_wb = 1; e_alu_t = 2; e_wb_t = 3;
        end else if (op < 24) begin
            e_lat = 2; e_trap = 1; e_cause = 1;
        end else begin
            e_lat = 3;
            case (op)
                24: begin e_pcw = 1; e_src = 2; end
                25: begin e_pcw = zf ? 1 : 0; e_src = zf ? 1 : 0; end
                26: begin e_pcw = zf ? 0 : 1; e_src = zf ? 0 : 1; end
                27: if (m_depth == SD) begin e_trap = 1; e_cause = 2; end
                    else begin e_push = 1; e_pcw = 1; e_src = 3; m_depth++; end
                28: if (m_depth == 0) begin e_trap = 1; e_cause = 3; end
                    else begin e_pop = 1; e_pcw = 1; e_src = 4; m_depth--; end
                29, 30: if (delay < MT) begin
                        if (op == 29) begin
                            e_rd = delay + 1; e_wb = 1; e_wb_t = 4 + delay; e_lat = 5 + delay;
                        end else begin
                            e_wr = delay + 1; e_lat = 4 + delay;
                        end
                    end else begin
                        e_trap = 1; e_cause = 4; e_lat = 3 + MT;
                        if (op == 29) e_rd = MT; else e_wr = MT;
                    end
                default: begin e_halt = 1; e_lat = 2; end
            endcase
        end

        present(op, stall, ok);
        if (!ok) return;

        lat = 99; alu = 0; wb = 0; alu_t = -1; wb_t = -1; pcw = 0; src = 0;
        psh = 0; pp = 0; rd = 0; wr = 0; k = 0; stop = 0;
        for (int t = 1; t <= 40 && !stop; t++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            bus.opcode      = OPW'($urandom);
            bus.zero_flag   = zf;
            #1;
            if (bus.fetch_req || bus.trap || bus.halted) begin
                lat  = t;
                stop = 1;
            end else begin
                if (bus.alu_en) begin alu++; if (alu_t < 0) alu_t = t; end
                if (bus.reg_write) begin wb++; if (wb_t < 0) wb_t = t; end
                if (bus.pc_write) begin pcw++; src = int'(bus.pc_src); end
                if (bus.stack_push) psh++;
                if (bus.stack_pop) pp++;
                if (bus.mem_read) rd++;
                if (bus.mem_write) wr++;
                if (bus.mem_read || bus.mem_write) begin
                    bus.mem_ready = (k == delay);
                    k++;
                end else begin
                    bus.mem_ready = 1'($urandom);
                end
            end
        end

        chk("latency", lat, e_lat);
        chk("alu_en_cnt", alu, e_alu);
        chk("alu_en_cyc", alu_t, e_alu_t);
        chk("reg_write_cnt", wb, e_wb);
        chk("reg_write_cyc", wb_t, e_wb_t);
        chk("pc_write_cnt", pcw, e_pcw);
        chk("pc_src", src, e_src);
        chk("push_cnt", psh, e_push);
        chk("pop_cnt", pp, e_pop);
        chk("mem_read_cyc", rd, e_rd);
        chk("mem_write_cyc", wr, e_wr);
        chk("depth", 32'(bus.stack_depth), m_depth);
        chk("trap", 32'(bus.trap), 32'(e_trap));
        chk("trap_cause", 32'(bus.trap_cause), e_cause);
        chk("halted", 32'(bus.halted), 32'(e_halt));

        if (e_trap || e_halt) begin
            quiet = 0;
            repeat (4) begin
                @(negedge clk);
                bus.mem_ready = 1'($urandom);
                bus.instr_valid = 1'($urandom);
                #1;
                if (strobes() || bus.trap != e_trap || bus.halted != e_halt) quiet++;
            end
            chk("dead_quiet", quiet, 0);
            m_dead = 1;
        end
    endtask

    // Reset lands while an LD request is being held in MEM.
    task automatic mem_reset();
        bit ok;
        int n;
        present(29, 0, ok);
        n = 0;
        for (int t = 0; t < 10 && n < 2; t++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            bus.mem_ready   = 1'b0;
            #1;
            if (bus.mem_read) n++;
        end
        chk("mid_mem_req", n, 2);
        #1 rst_n = 1'b0;
        #1 chk("mid_mem_reset", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_depth = 0;
        m_dead  = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, op;
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.zero_flag   = 1'b0;
        bus.mem_ready   = 1'b0;

        do_reset();
        run(0, 0, 0, 0);
        run(25, 1, 0, 0);
        run(26, 1, 0, 1);
        for (int i = 0; i < 17; i++) run(27, 0, 0, 0);
        do_reset();
        run(28, 0, 0, 0);
        do_reset();
        run(29, 0, 3, 0);
        run(30, 0, MT - 1, 0);
        run(30, 0, 50, 0);
        do_reset();
        run(21, 0, 0, 0);
        do_reset();
        run(31, 0, 0, 0);
        do_reset();
        mem_reset();

        for (int i = 0; i < 250; i++) begin
            if (m_dead) do_reset();
            r = $urandom_range(0, 19);
            case (r)
                0, 1, 2, 3, 4, 5: op = $urandom_range(0, 19);
                6:      op = 24;
                7:      op = 25;
                8:      op = 26;
                9, 10, 11: op = 27;
                12, 13: op = 28;
                14, 15: op = 29;
                16, 17: op = 30;
                18:     op = $urandom_range(20, 23);
                default: op = 31;
            endcase
            run(op, 1'($urandom), $urandom_range(0, MT + 1), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
